// File: rtl/bist_pkg.sv
// bist_pkg: shared types and constants for the BIST controller slice.
//   state_t        controller FSM states
//   LFSR_TAPS      feedback tap mask (x^4+x^3+1), shared by the LFSR and the MISR
//   DEF_WIDTH      default pattern/response/signature width
//   DEF_PATTERNS   default number of patterns applied per run
//   DEF_SEED       default LFSR value at run start (must be nonzero)
//   DEF_GOLDEN     default expected final signature
package bist_pkg;
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;
   localparam int         DEF_WIDTH    = 4;
   localparam int         DEF_PATTERNS = 15;
   localparam logic [3:0] LFSR_TAPS    = 4'b1100;
   localparam logic [3:0] DEF_SEED     = 4'b0001;
   localparam logic [3:0] DEF_GOLDEN   = 4'h8;
endpackage

// File: rtl/bist_controller_if.sv
// bist_controller_if: handshake and data bundle between the TAP/core side and the BIST engine.
//   start        TAP request level (RUNBIST)
//   bist_in      core response
//   bist_out     pattern driven to the core
//   bist_enable  core_logic mux select
//   busy         run in progress
//   done         run finished
//   pass         final signature matched the golden value
//   signature    final MISR value
//   modport slave  : the BIST engine
//   modport master : the TAP/core side
interface bist_controller_if #(parameter int WIDTH = 4);
   logic             start;
   logic [WIDTH-1:0] bist_in;
   logic [WIDTH-1:0] bist_out;
   logic             bist_enable;
   logic             busy;
   logic             done;
   logic             pass;
   logic [WIDTH-1:0] signature;
   modport slave (
      input  start, bist_in,
      output bist_out, bist_enable, busy, done, pass, signature
   );
   modport master (
      output start, bist_in,
      input  bist_out, bist_enable, busy, done, pass, signature
   );
endinterface

// File: rtl/bist_misr.sv
// bist_misr: multiple-input signature register compacting the core response.
//   clk       test clock
//   rst_n     asynchronous active-low reset (clears the signature)
//   clr       synchronous clear of the signature
//   en        absorb din on this edge
//   din       response word
//   sig_next  signature the register takes if din is absorbed this edge
module bist_misr import bist_pkg::*; #(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             en,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] sig_next
);
   localparam logic [WIDTH-1:0] TAP_MASK = WIDTH'(LFSR_TAPS);
   logic [WIDTH-1:0] sig;
   // Same shift/feedback as the pattern LFSR, with the response folded in.
   assign sig_next = {sig[WIDTH-2:0], ^(sig & TAP_MASK)} ^ din;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)   sig <= '0;
      else if (clr) sig <= '0;
      else if (en)  sig <= sig_next;
   end
endmodule

// File: rtl/bist_controller.sv
// bist_controller: BIST engine driving LFSR patterns into the core and checking a MISR signature.
//   tck   test clock, all state changes on its rising edge
//   trst  asynchronous active-low reset
//   bus   bist_controller_if.slave: start/bist_in in; bist_out, bist_enable, busy,
//         done, pass, signature out
module bist_controller import bist_pkg::*; #(
   parameter int             WIDTH      = DEF_WIDTH,
   parameter int             PATTERNS   = DEF_PATTERNS,
   parameter logic [WIDTH-1:0] LFSR_SEED  = WIDTH'(DEF_SEED),
   parameter logic [WIDTH-1:0] GOLDEN_SIG = WIDTH'(DEF_GOLDEN)
) (
   input logic             tck,
   input logic             trst,
   bist_controller_if.slave bus
);
   localparam int               CW       = $clog2(PATTERNS + 1);
   localparam logic [WIDTH-1:0] TAP_MASK = WIDTH'(LFSR_TAPS);
   state_t           state, state_next;
   logic [WIDTH-1:0] lfsr, sig_q, misr_next;
   logic [CW-1:0]    count;
   logic             run_q, pass_q;
   logic             launch, absorb, abort, last;
   bist_misr #(.WIDTH(WIDTH)) u_misr (
      .clk      (tck),
      .rst_n    (trst),
      .clr      (launch),
      .en       (absorb),
      .din      (bus.bist_in),
      .sig_next (misr_next)
   );
   always_comb begin
      state_next = state;
      launch     = 1'b0;
      absorb     = 1'b0;
      abort      = 1'b0;
      last       = count == CW'(PATTERNS - 1);
      case (state)
         IDLE: if (bus.start) begin
            state_next = RUN;
            launch     = 1'b1;
         end
         RUN: if (!bus.start) begin
            state_next = IDLE;
            abort      = 1'b1;
         end else begin
            absorb     = 1'b1;
            state_next = last ? DONE : RUN;
         end
         DONE:    state_next = bus.start ? DONE : IDLE;
         default: state_next = IDLE;
      endcase
   end
   always_ff @(posedge tck or negedge trst) begin
      if (!trst) begin
         state  <= IDLE;
         lfsr   <= LFSR_SEED;
         count  <= '0;
         run_q  <= 1'b0;
         pass_q <= 1'b0;
         sig_q  <= '0;
      end else begin
         state <= state_next;
         run_q <= state_next == RUN;
         if (launch) begin
            lfsr   <= LFSR_SEED;
            count  <= '0;
            pass_q <= 1'b0;
         end else if (absorb) begin
            lfsr  <= {lfsr[WIDTH-2:0], ^(lfsr & TAP_MASK)};
            count <= count + 1'b1;
            if (last) begin
               sig_q  <= misr_next;
               pass_q <= misr_next == GOLDEN_SIG;
            end
         end else if (abort) begin
            pass_q <= 1'b0;
         end
      end
   end
   // Patterns are gated by the registered run flag so nothing reaches the core outside RUN.
   assign bus.bist_out    = run_q ? lfsr : '0;
   assign bus.bist_enable = run_q;
   assign bus.busy        = run_q;
   assign bus.done        = state == DONE;
   assign bus.pass        = pass_q;
   assign bus.signature   = sig_q;
endmodule

// File: tb/tb_bist_controller.sv
module tb_bist_controller;
   logic       tck = 1'b0;
   logic       trst = 1'b0;
   int         mode = 0;
   logic [3:0] rsp = '0;
   int         errors = 0;
   int         checks = 0;
   logic [3:0] last_sig = '0;
   logic       last_pass = 1'b0;
   logic [3:0] spec_tab [15] = '{4'h1, 4'h2, 4'h4, 4'h9, 4'h3, 4'h6, 4'hD, 4'hA,
                                 4'h5, 4'hB, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8};
   always #5 tck = ~tck;
   bist_controller_if #(.WIDTH(4)) b ();
   bist_controller_if #(.WIDTH(4)) b1 ();
   assign b.bist_in  = (mode == 0) ? b.bist_out : (mode == 1) ? (b.bist_out & 4'hE) : rsp;
   assign b1.bist_in = b1.bist_out;
   bist_controller #(.WIDTH(4), .PATTERNS(15)) u_dut (.tck(tck), .trst(trst), .bus(b.slave));
   bist_controller #(.WIDTH(4), .PATTERNS(1))  u_dut1 (.tck(tck), .trst(trst), .bus(b1.slave));

   function automatic logic [3:0] step(input logic [3:0] v);
      int n;
      n = int'(v);
      return 4'(((n * 2) % 16) + (((n / 8) ^ (n / 4)) % 2));
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge tck);
      #1;
   endtask

   task automatic run(input int md, input int abort_at);
      logic [3:0] x, m, r;
      x = 4'h1;
      m = 4'h0;
      mode = md;
      b.start = 1'b1;
      tick();
      for (int i = 0; i < 15; i++) begin
         if (i == abort_at) begin
            b.start = 1'b0;
            tick();
            chk("abort_enable", 32'(b.bist_enable), 32'd0);
            chk("abort_busy", 32'(b.busy), 32'd0);
            chk("abort_out", 32'(b.bist_out), 32'd0);
            chk("abort_done", 32'(b.done), 32'd0);
            chk("abort_pass", 32'(b.pass), 32'd0);
            chk("abort_sig", 32'(b.signature), 32'(last_sig));
            last_pass = 1'b0;
            return;
         end
         if (md == 2) rsp = 4'($urandom);
         chk("busy", 32'(b.busy), 32'd1);
         chk("enable", 32'(b.bist_enable), 32'd1);
         chk("pattern", 32'(b.bist_out), 32'(x));
         if (md == 0) chk("spec_pattern", 32'(b.bist_out), 32'(spec_tab[i]));
         chk("done_early", 32'(b.done), 32'd0);
         r = (md == 0) ? x : (md == 1) ? (x & 4'hE) : rsp;
         m = step(m) ^ r;
         x = step(x);
         tick();
      end
      chk("done", 32'(b.done), 32'd1);
      chk("done_busy", 32'(b.busy), 32'd0);
      chk("done_enable", 32'(b.bist_enable), 32'd0);
      chk("done_out", 32'(b.bist_out), 32'd0);
      chk("signature", 32'(b.signature), 32'(m));
      chk("pass", 32'(b.pass), 32'(m == 4'h8));
      last_sig = m;
      last_pass = (m == 4'h8);
   endtask

   task automatic end_run();
      b.start = 1'b0;
      tick();
      chk("idle_done", 32'(b.done), 32'd0);
      chk("idle_busy", 32'(b.busy), 32'd0);
      chk("hold_sig", 32'(b.signature), 32'(last_sig));
      chk("hold_pass", 32'(b.pass), 32'(last_pass));
   endtask

   initial begin
      b.start = 1'b0;
      b1.start = 1'b0;
      tick();
      tick();
      chk("rst_out", 32'(b.bist_out), 32'd0);
      chk("rst_enable", 32'(b.bist_enable), 32'd0);
      chk("rst_busy", 32'(b.busy), 32'd0);
      chk("rst_done", 32'(b.done), 32'd0);
      chk("rst_pass", 32'(b.pass), 32'd0);
      chk("rst_sig", 32'(b.signature), 32'd0);
      trst = 1'b1;
      tick();
      tick();
      chk("idle_stays", 32'(b.busy), 32'd0);
      run(0, -1);
      chk("loop_sig_const", 32'(b.signature), 32'h8);
      chk("loop_pass_const", 32'(b.pass), 32'd1);
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("hold_done", 32'(b.done), 32'd1);
         chk("no_rerun", 32'(b.busy), 32'd0);
      end
      end_run();
      run(0, -1);
      chk("rerun_sig", 32'(b.signature), 32'h8);
      end_run();
      run(1, -1);
      chk("stuck_sig_const", 32'(b.signature), 32'hC);
      chk("stuck_pass_const", 32'(b.pass), 32'd0);
      end_run();
      run(0, 5);
      run(0, -1);
      chk("after_abort_sig", 32'(b.signature), 32'h8);
      end_run();
      mode = 0;
      b.start = 1'b1;
      repeat (4) @(posedge tck);
      #2;
      trst = 1'b0;
      #1;
      chk("arst_out", 32'(b.bist_out), 32'd0);
      chk("arst_enable", 32'(b.bist_enable), 32'd0);
      chk("arst_busy", 32'(b.busy), 32'd0);
      chk("arst_done", 32'(b.done), 32'd0);
      chk("arst_pass", 32'(b.pass), 32'd0);
      chk("arst_sig", 32'(b.signature), 32'd0);
      last_sig = '0;
      last_pass = 1'b0;
      b.start = 1'b0;
      tick();
      trst = 1'b1;
      tick();
      run(0, -1);
      chk("post_rst_sig", 32'(b.signature), 32'h8);
      end_run();
      for (int k = 0; k < 6; k++) begin
         run(2, ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 14)) : -1);
         end_run();
      end
      b1.start = 1'b1;
      tick();
      chk("p1_busy", 32'(b1.busy), 32'd1);
      chk("p1_out", 32'(b1.bist_out), 32'h1);
      chk("p1_done_early", 32'(b1.done), 32'd0);
      tick();
      chk("p1_done", 32'(b1.done), 32'd1);
      chk("p1_sig", 32'(b1.signature), 32'h1);
      chk("p1_pass", 32'(b1.pass), 32'd0);
      b1.start = 1'b0;
      tick();
      chk("p1_idle", 32'(b1.done), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
